bcd_add_sched: RTL and testbench
================================

# bcd_add_sched

Two-requester scheduler for the shared pipelined BCD adder in the decimal FPU. Arbitrates add/subtract requests round-robin, issues at most one operation per cycle into a fixed-latency adder, tracks in-flight operations with a tag pipeline, and returns each result on the owning requester's response port. Performs subtraction as ten's-complement addition, with an automatic second adder pass (re-complement) when the difference is negative.

## Interface
- N, 33: operand width in bytes; D = 2N packed BCD digits, 8N bits.
- ADD_LAT, 3: adder latency; operands present in cycle c → add_o/add_co valid in cycle c+ADD_LAT. Must be ≥1.
- TAG_W, 4: requester tag width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqI_valid  in  1  (I=0,1) request valid.
- reqI_ready  out  1  request granted this cycle.
- reqI_a, reqI_b  in  8N  BCD operands.
- reqI_sub  in  1  1 = a−b, 0 = a+b.
- reqI_tag  in  TAG_W  returned unchanged on the response.
- respI_valid  out  1  one-cycle result strobe; no backpressure.
- respI_o  out  8N  sum, or magnitude of the difference.
- respI_co  out  1  add: carry out; sub: borrow (1 = a<b).
- respI_neg  out  1  sub result negative (equals borrow); 0 for add.
- respI_tag  out  TAG_W  tag of the completed request.
- add_a, add_b  out  8N  registered adder operands.
- add_ci  out  1  registered adder carry in.
- add_o  in  8N  adder sum.
- add_co  in  1  adder carry out.
- busy  out  1  any operation in flight or re-complement pending.

## Operation
- Tag pipeline: ADD_LAT+1 stages of {valid, req_id, kind, tag}, advancing every cycle. kind ∈ {ADD, SUB, RECOMP}. The entry launches with the operand registers and exits in the cycle add_o is valid.
- Issue: on grant, add_a ← a. For ADD: add_b ← b, add_ci ← 0. For SUB: add_b ← nines complement of b (each digit d → 9−d), add_ci ← 1.
- Idle cycles: add_a = add_b = 0, add_ci = 0, launched entry invalid.
- Exit handling:
  - ADD: resp o = add_o, co = add_co, neg = 0.
  - SUB with add_co=1: o = add_o, co = 0, neg = 0. a=b gives o=0, neg=0.
  - SUB with add_co=0: no response. In the same cycle, load add_a ← nines complement of add_o, add_b ← 0, add_ci ← 1, and launch RECOMP with the same req_id and tag.
  - RECOMP: o = add_o, co = 1, neg = 1.
- Arbitration: in a cycle where the exiting entry is SUB with add_co=0, both ready outputs are 0; RECOMP owns the slot. Otherwise:
  - One requester valid: that requester is granted.
  - Both valid: grant the requester not granted most recently; the pointer updates only on a grant.
  - After reset, req0 wins the first tie.
- reqI_ready is combinational from reqI_valid, the other valid, the pointer, and the exit state. Ready is never asserted without valid.
- Responses may complete out of order, e.g. a negative SUB is overtaken by a later ADD. Requesters reorder by tag.
- Only one entry exits per cycle, so response ports never conflict and only one port strobes per cycle.
- Operands must be valid BCD; results for non-BCD digits are undefined but must not corrupt the scheduler state.
- busy = OR of all pipeline valid bits.

## Timing
- Handshake in cycle c (valid & ready at the rising edge ending c). Operands are on add_* during cycle c+1.
- ADD, or SUB with non-negative result: respI_valid in cycle c+ADD_LAT+2 (5 at default).
- Negative SUB: RECOMP operands in cycle c+ADD_LAT+2; response in cycle c+2·ADD_LAT+3 (9 at default). It costs one issue slot (cycle c+ADD_LAT+1).
- Throughput: one issue per cycle, minus stolen RECOMP slots.
- Reset: all outputs and registers go to 0 and the pointer resets.
  - Reset asserted mid-operation discards in-flight entries. No response is ever produced for an operation accepted before reset.
  - First grant is possible in the first cycle after rst_n deasserts.

## Test plan
Bench uses N=2, ADD_LAT=3, TAG_W=4.
1. req0 ADD a=0x1234, b=0x8766, tag=3 in cycle c → resp0 in c+5: o=0x0000, co=1, neg=0, tag=3; resp1 silent.
2. req1 SUB a=0x5000, b=0x1234 → add_b=0x8765, add_ci=1 in c+1; resp1 in c+5: o=0x3766, co=0, neg=0.
3. req0 SUB a=0x0100, b=0x0250 → both ready=0 in c+4; add_a=0x0149, add_b=0, add_ci=1 in c+5; resp0 in c+9: o=0x0150, neg=1, co=1. Also SUB a=b=0x4321 → o=0x0000, neg=0 in c+5.
4. Both requesters valid continuously for 10 cycles, distinct tags → grants alternate 0,1,0,… starting with req0; one issue per cycle; every tag returns exactly once on the correct port.
5. Negative SUB from req0 followed next cycle by ADD from req1 → the ADD response (c+6) precedes the SUB response (c+9); RECOMP slot correctly steals the grant in c+4.
6. Three operations in flight, rst_n pulsed low asynchronously mid-cycle → all outputs 0 immediately; busy=0; no respI_valid after release until new requests complete.

Source files
------------

// File: rtl/bcd_add_sched.sv
// bcd_add_sched: round-robin scheduler for the shared pipelined BCD adder.
// Subtraction is a ten's-complement add, re-complemented when negative.
module bcd_add_sched #(
  parameter int N       = 33,
  parameter int ADD_LAT = 3,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [8*N-1:0]   req0_a,
  input  logic [8*N-1:0]   req0_b,
  input  logic             req0_sub,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [8*N-1:0]   req1_a,
  input  logic [8*N-1:0]   req1_b,
  input  logic             req1_sub,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp0_valid,
  output logic [8*N-1:0]   resp0_o,
  output logic             resp0_co,
  output logic             resp0_neg,
  output logic [TAG_W-1:0] resp0_tag,
  output logic             resp1_valid,
  output logic [8*N-1:0]   resp1_o,
  output logic             resp1_co,
  output logic             resp1_neg,
  output logic [TAG_W-1:0] resp1_tag,
  output logic [8*N-1:0]   add_a,
  output logic [8*N-1:0]   add_b,
  output logic             add_ci,
  input  logic [8*N-1:0]   add_o,
  input  logic             add_co,
  output logic             busy
);
  localparam int W = 8 * N;
  localparam int S = ADD_LAT + 1;

  typedef enum logic [1:0] {K_ADD, K_SUB, K_RCP} kind_e;

  typedef struct packed {
    logic             v;
    logic             id;
    kind_e            kind;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t [S-1:0] pipe;
  ent_t         ex;
  ent_t         launch;
  logic         ptr;
  logic         recomp;
  logic         g0;
  logic         g1;
  logic         rv;
  logic         rco;
  logic         rneg;
  logic [W-1:0] na;
  logic [W-1:0] nb;
  logic         nci;

  function automatic logic [W-1:0] nines(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 2 * N; i++)
      r[4*i +: 4] = 4'd9 - x[4*i +: 4];
    return r;
  endfunction

  assign ex     = pipe[S-1];
  assign recomp = ex.v && (ex.kind == K_SUB) && !add_co;

  // ptr = 0 gives req0 priority on a tie
  assign g0 = !recomp && req0_valid && (!req1_valid || !ptr);
  assign g1 = !recomp && req1_valid && (!req0_valid || ptr);

  assign req0_ready = g0;
  assign req1_ready = g1;

  always_comb begin
    na     = '0;
    nb     = '0;
    nci    = 1'b0;
    launch = '0;
    unique case (1'b1)
      recomp: begin
        na     = nines(add_o);
        nci    = 1'b1;
        launch = '{v: 1'b1, id: ex.id, kind: K_RCP, tag: ex.tag};
      end
      g0: begin
        na     = req0_a;
        nb     = req0_sub ? nines(req0_b) : req0_b;
        nci    = req0_sub;
        launch = '{v: 1'b1, id: 1'b0,
                   kind: req0_sub ? K_SUB : K_ADD, tag: req0_tag};
      end
      g1: begin
        na     = req1_a;
        nb     = req1_sub ? nines(req1_b) : req1_b;
        nci    = req1_sub;
        launch = '{v: 1'b1, id: 1'b1,
                   kind: req1_sub ? K_SUB : K_ADD, tag: req1_tag};
      end
      default: ;
    endcase
  end

  always_comb begin
    rv   = ex.v && !recomp;
    rco  = 1'b0;
    rneg = 1'b0;
    unique case (ex.kind)
      K_ADD:   rco = add_co;
      K_RCP: begin
        rco  = 1'b1;
        rneg = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < S; i++)
      busy = busy | pipe[i].v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe        <= '0;
      ptr         <= 1'b0;
      add_a       <= '0;
      add_b       <= '0;
      add_ci      <= 1'b0;
      resp0_valid <= 1'b0;
      resp0_o     <= '0;
      resp0_co    <= 1'b0;
      resp0_neg   <= 1'b0;
      resp0_tag   <= '0;
      resp1_valid <= 1'b0;
      resp1_o     <= '0;
      resp1_co    <= 1'b0;
      resp1_neg   <= 1'b0;
      resp1_tag   <= '0;
    end else begin
      pipe   <= {pipe[S-2:0], launch};
      add_a  <= na;
      add_b  <= nb;
      add_ci <= nci;
      if (g0)
        ptr <= 1'b1;
      else if (g1)
        ptr <= 1'b0;
      resp0_valid <= rv && !ex.id;
      resp1_valid <= rv && ex.id;
      if (rv && !ex.id) begin
        resp0_o   <= add_o;
        resp0_co  <= rco;
        resp0_neg <= rneg;
        resp0_tag <= ex.tag;
      end
      if (rv && ex.id) begin
        resp1_o   <= add_o;
        resp1_co  <= rco;
        resp1_neg <= rneg;
        resp1_tag <= ex.tag;
      end
    end
  end

endmodule

// File: tb/tb_bcd_add_sched.sv
// tb_bcd_add_sched: scoreboard bench for the BCD adder scheduler,
// with a behavioural pipelined BCD adder attached.
module tb_bcd_add_sched;
  localparam int N       = 2;
  localparam int ADD_LAT = 3;
  localparam int TAG_W   = 4;
  localparam int W       = 8 * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_sub = 1'b0, req1_sub = 1'b0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic resp0_valid, resp1_valid;
  logic [W-1:0] resp0_o, resp1_o;
  logic resp0_co, resp1_co, resp0_neg, resp1_neg;
  logic [TAG_W-1:0] resp0_tag, resp1_tag;
  logic [W-1:0] add_a, add_b, add_o;
  logic add_ci, add_co, busy;

  always #5 clk = ~clk;

  bcd_add_sched #(.N(N), .ADD_LAT(ADD_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_tag(req1_tag),
    .resp0_valid(resp0_valid), .resp0_o(resp0_o),
    .resp0_co(resp0_co), .resp0_neg(resp0_neg), .resp0_tag(resp0_tag),
    .resp1_valid(resp1_valid), .resp1_o(resp1_o),
    .resp1_co(resp1_co), .resp1_neg(resp1_neg), .resp1_tag(resp1_tag),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_o(add_o), .add_co(add_co), .busy(busy)
  );

  function automatic logic [W:0] bcdadd(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic ci);
    logic [W-1:0] r;
    logic [4:0] s;
    logic c;
    r = '0;
    c = ci;
    for (int i = 0; i < 2 * N; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else
        c = 1'b0;
      r[4*i +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  logic [ADD_LAT-1:0][W:0] apipe;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) apipe <= '0;
    else apipe <= {apipe[ADD_LAT-2:0], bcdadd(add_a, add_b, add_ci)};
  assign add_o  = apipe[ADD_LAT-1][W-1:0];
  assign add_co = apipe[ADD_LAT-1][W];

  typedef struct {
    int p; logic [3:0] tag; logic [15:0] o;
    logic co; logic neg; int lat; int cyc;
  } exp_t;

  exp_t sb[$];
  int   steal[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  logic bptr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int b2i(input logic [15:0] x);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] i2b(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input int p, input logic [15:0] a,
                                 input logic [15:0] b, input logic sub,
                                 input logic [3:0] tag, input int c);
    exp_t e;
    int x = b2i(a), y = b2i(b), s;
    e.p = p; e.tag = tag; e.cyc = c; e.lat = 5;
    e.co = 1'b0; e.neg = 1'b0;
    if (!sub) begin
      s = x + y;
      e.co = (s >= 10000);
      e.o = i2b(s % 10000);
    end else if (x >= y)
      e.o = i2b(x - y);
    else begin
      e.o = i2b(y - x); e.co = 1'b1; e.neg = 1'b1; e.lat = 9;
    end
    return e;
  endfunction

  task automatic push(input int p, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic [3:0] tag);
    exp_t e = model(p, a, b, sub, tag, cyc);
    sb.push_back(e);
    if (e.neg) steal.push_back(cyc + 4);
  endtask

  task automatic match(input int p, input logic [15:0] o, input logic co,
                       input logic neg, input logic [3:0] tag);
    int k = -1;
    foreach (sb[i]) if (k < 0 && sb[i].p == p && sb[i].tag == tag) k = i;
    check("resp_known", 32'(k >= 0), 1);
    if (k >= 0) begin
      check("resp_o", o, sb[k].o);
      check("resp_co", co, sb[k].co);
      check("resp_neg", neg, sb[k].neg);
      check("latency", cyc - sb[k].cyc, sb[k].lat);
      sb.delete(k);
    end
  endtask

  always @(negedge clk) begin
    logic stl, e0, e1;
    if (!rst_n) begin
      sb.delete();
      steal.delete();
      bptr = 1'b0;
    end else begin
      if (resp0_valid || resp1_valid)
        check("one_port", resp0_valid & resp1_valid, 0);
      if (resp0_valid) match(0, resp0_o, resp0_co, resp0_neg, resp0_tag);
      if (resp1_valid) match(1, resp1_o, resp1_co, resp1_neg, resp1_tag);
      stl = 1'b0;
      foreach (steal[i]) if (steal[i] == cyc) stl = 1'b1;
      e0 = !stl && req0_valid && (!req1_valid || !bptr);
      e1 = !stl && req1_valid && (!req0_valid || bptr);
      if (req0_valid || req1_valid) begin
        check("ready0", req0_ready, e0);
        check("ready1", req1_ready, e1);
      end
      if (req0_valid && req0_ready) begin
        push(0, req0_a, req0_b, req0_sub, req0_tag);
        bptr = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        push(1, req1_a, req1_b, req1_sub, req1_tag);
        bptr = 1'b0;
      end
    end
  end

  task automatic drive(input int p, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic [3:0] tag);
    if (p == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
      req0_sub = sub; req0_tag = tag;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
      req1_sub = sub; req1_tag = tag;
    end
  endtask

  task automatic send(input int p, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic [3:0] tag);
    logic ok = 1'b0;
    drive(p, a, b, sub, tag);
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = (p == 0) ? req0_ready : req1_ready;
    end
    check("grant_timeout", ok, 1);
    @(posedge clk); #1;
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  function automatic logic [15:0] rbcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    int c;
    int cnt;
    logic g0, g1;
    logic [3:0] tg;
    logic [15:0] ra, rb, rt;

    #12;
    check("rst_add_a", add_a, 0);
    check("rst_busy", busy, 0);
    check("rst_resp0", resp0_valid, 0);
    check("rst_resp1", resp1_valid, 0);
    check("rst_ready0", req0_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // plain add with decimal carry out
    send(0, 16'h1234, 16'h8766, 1'b0, 4'd3);
    repeat (8) @(posedge clk);
    #1;

    // negative subtraction with re-complement pass
    send(0, 16'h0100, 16'h0250, 1'b1, 4'd5);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    check("t3_add_a", add_a, 16'h0149);
    check("t3_add_b", add_b, 16'h0000);
    check("t3_add_ci", add_ci, 1);
    send(0, 16'h4321, 16'h4321, 1'b1, 4'd6);
    repeat (10) @(posedge clk);
    #1;

    // positive subtraction
    send(1, 16'h5000, 16'h1234, 1'b1, 4'd7);
    check("t2_add_b", add_b, 16'h8765);
    check("t2_add_ci", add_ci, 1);
    repeat (8) @(posedge clk);
    #1;

    // both requesters valid for 10 cycles
    tg = 4'd0;
    ra = rbcd(); rb = rbcd();
    drive(0, ra, rb, 1'b0, tg); tg++;
    ra = rbcd(); rb = rbcd();
    drive(1, ra, rb, 1'b0, tg); tg++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      g0 = req0_ready; g1 = req1_ready;
      check("one_issue", 32'(g0) + 32'(g1), 1);
      check("alternate", g0, 32'(k % 2 == 0));
      @(posedge clk); #1;
      ra = rbcd(); rb = rbcd();
      if (tg[0] && ra < rb) begin rt = ra; ra = rb; rb = rt; end
      if (g0) begin drive(0, ra, rb, tg[0], tg); tg++; end
      if (g1) begin drive(1, ra, rb, tg[0], tg); tg++; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // later ADDs overtake a negative SUB; RECOMP steals a slot
    send(0, 16'h0012, 16'h0345, 1'b1, 4'd1);
    c = cyc - 1;
    send(1, 16'h0999, 16'h0001, 1'b0, 4'd2);
    send(1, 16'h5555, 16'h4445, 1'b0, 4'd3);
    send(1, 16'h0042, 16'h0058, 1'b0, 4'd4);
    send(1, 16'h9999, 16'h9999, 1'b0, 4'd5);
    check("steal_slot", (cyc - 1) - c, 5);
    repeat (12) @(posedge clk);
    #1;

    // asynchronous reset with three ops in flight
    send(0, 16'h1111, 16'h2222, 1'b0, 4'd8);
    send(1, 16'h3333, 16'h4444, 1'b0, 4'd9);
    send(0, 16'h0001, 16'h0002, 1'b1, 4'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_add_a", add_a, 0);
    check("arst_add_ci", add_ci, 0);
    check("arst_resp0", resp0_valid, 0);
    check("arst_resp1", resp1_valid, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cnt += int'(resp0_valid | resp1_valid);
    end
    check("post_reset_silent", cnt, 0);

    // first tie after reset goes to req0
    @(posedge clk); #1;
    drive(0, 16'h0500, 16'h0500, 1'b0, 4'd11);
    drive(1, 16'h0700, 16'h0300, 1'b1, 4'd12);
    @(negedge clk);
    check("tie_req0", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("tie_req1", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
